// File: rtl/mem_loader_if.sv
// rtl/mem_loader_if.sv - load/dump streams and external memory ports of mem_loader
interface mem_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [63:0] addr_ext;
  logic        wen_ext;
  logic        ren_ext;
  logic [31:0] wdata_ext;
  logic [31:0] rdata_ext;
  logic [63:0] addr_ext_2;
  logic        wen_ext_2;
  logic        ren_ext_2;
  logic [63:0] wdata_ext_2;
  logic [63:0] rdata_ext_2;

  // Loader side: accepts the load stream, produces the dump stream, drives memories
  modport master (
    input  in_valid, in_data, out_ready, rdata_ext, rdata_ext_2,
    output in_ready, out_valid, out_data,
    output addr_ext, wen_ext, ren_ext, wdata_ext,
    output addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2
  );

  // Host/memory side
  modport slave (
    output in_valid, in_data, out_ready, rdata_ext, rdata_ext_2,
    input  in_ready, out_valid, out_data,
    input  addr_ext, wen_ext, ren_ext, wdata_ext,
    input  addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2
  );
endinterface

// File: rtl/mem_loader.sv
// rtl/mem_loader.sv - loads CPU instruction/data memories, runs the CPU, dumps data memory
module mem_loader #(
  parameter int IMEM_DEPTH = 512,
  parameter int DMEM_DEPTH = 1024
) (
  input  logic          clk,
  input  logic          arst,
  input  logic          start,
  input  logic [9:0]    imem_count,
  input  logic [10:0]   dmem_count,
  input  logic [31:0]   run_cycles,
  input  logic [10:0]   dump_count,
  output logic          cpu_rst_n,
  output logic          cpu_enable,
  output logic          busy,
  output logic          done,
  mem_loader_if.master  bus
);

  typedef enum logic [3:0] {
    IDLE, LOAD_I, LOAD_D, RELEASE, RUN, DUMP_REQ, DUMP_CAP, DUMP_OUT, DONE
  } state_t;

  localparam logic [10:0] IMEM_MAX = 11'(IMEM_DEPTH);
  localparam logic [10:0] DMEM_MAX = 11'(DMEM_DEPTH);

  state_t      state_q, state_d;
  logic [10:0] idx_q;
  logic [10:0] imem_n, dmem_n, dump_n;
  logic [31:0] run_n, cyc_q;
  logic [63:0] out_data_q;
  logic        cpu_enable_d, out_valid_d;
  logic [10:0] imem_clamp, dmem_clamp, dump_clamp;

  // Counts beyond the memory depth are clamped as they are latched
  assign imem_clamp = ({1'b0, imem_count} > IMEM_MAX) ? IMEM_MAX : {1'b0, imem_count};
  assign dmem_clamp = (dmem_count > DMEM_MAX) ? DMEM_MAX : dmem_count;
  assign dump_clamp = (dump_count > DMEM_MAX) ? DMEM_MAX : dump_count;

  // Reset must kill the CPU enable and the dump offer in the very cycle it is raised
  assign cpu_enable    = cpu_enable_d & ~arst;
  assign bus.out_valid = out_valid_d & ~arst;
  assign bus.out_data  = out_data_q;
  assign busy          = !(state_q inside {IDLE, DONE});
  assign done          = (state_q == DONE);

  // Next state and per-state outputs; memory ports are zero unless a state drives them
  always_comb begin
    state_d         = state_q;
    bus.in_ready    = 1'b0;
    bus.addr_ext    = '0;
    bus.wen_ext     = 1'b0;
    bus.ren_ext     = 1'b0;
    bus.wdata_ext   = '0;
    bus.addr_ext_2  = '0;
    bus.wen_ext_2   = 1'b0;
    bus.ren_ext_2   = 1'b0;
    bus.wdata_ext_2 = '0;
    cpu_rst_n       = 1'b0;
    cpu_enable_d    = 1'b0;
    out_valid_d     = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        cpu_rst_n = (state_q == DONE);
        if (start) begin
          if (imem_clamp != 11'd0)      state_d = LOAD_I;
          else if (dmem_clamp != 11'd0) state_d = LOAD_D;
          else                          state_d = RELEASE;
        end
      end
      LOAD_I: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          bus.wen_ext   = 1'b1;
          bus.addr_ext  = {51'd0, idx_q, 2'b00};
          bus.wdata_ext = bus.in_data[31:0];
          if (idx_q == imem_n - 11'd1) state_d = (dmem_n != 11'd0) ? LOAD_D : RELEASE;
        end
      end
      LOAD_D: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          bus.wen_ext_2   = 1'b1;
          bus.addr_ext_2  = {50'd0, idx_q, 3'b000};
          bus.wdata_ext_2 = bus.in_data;
          if (idx_q == dmem_n - 11'd1) state_d = RELEASE;
        end
      end
      RELEASE: begin
        cpu_rst_n = 1'b1;
        if (run_n != 32'd0)       state_d = RUN;
        else if (dump_n != 11'd0) state_d = DUMP_REQ;
        else                      state_d = DONE;
      end
      RUN: begin
        cpu_rst_n    = 1'b1;
        cpu_enable_d = 1'b1;
        if (cyc_q == 32'd1) state_d = (dump_n != 11'd0) ? DUMP_REQ : DONE;
      end
      DUMP_REQ: begin
        cpu_rst_n      = 1'b1;
        bus.ren_ext_2  = 1'b1;
        bus.addr_ext_2 = {50'd0, idx_q, 3'b000};
        state_d        = DUMP_CAP;
      end
      DUMP_CAP: begin
        cpu_rst_n = 1'b1;
        state_d   = DUMP_OUT;
      end
      DUMP_OUT: begin
        cpu_rst_n   = 1'b1;
        out_valid_d = 1'b1;
        if (bus.out_ready) state_d = (idx_q == dump_n - 11'd1) ? DONE : DUMP_REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register, latched job parameters, word index, run counter and dump buffer
  always_ff @(posedge clk) begin
    if (arst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      imem_n     <= '0;
      dmem_n     <= '0;
      dump_n     <= '0;
      run_n      <= '0;
      cyc_q      <= '0;
      out_data_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            imem_n <= imem_clamp;
            dmem_n <= dmem_clamp;
            dump_n <= dump_clamp;
            run_n  <= run_cycles;
            idx_q  <= '0;
          end
        end
        LOAD_I:   if (bus.in_valid) idx_q <= (idx_q == imem_n - 11'd1) ? 11'd0 : idx_q + 11'd1;
        LOAD_D:   if (bus.in_valid) idx_q <= (idx_q == dmem_n - 11'd1) ? 11'd0 : idx_q + 11'd1;
        RELEASE:  cyc_q <= run_n;
        RUN:      cyc_q <= cyc_q - 32'd1;
        DUMP_CAP: out_data_q <= bus.rdata_ext_2;
        DUMP_OUT: if (bus.out_ready) idx_q <= (idx_q == dump_n - 11'd1) ? 11'd0 : idx_q + 11'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// tb/tb_mem_loader.sv - self-checking bench for mem_loader
module tb_mem_loader;
  logic        clk = 1'b0;
  logic        arst;
  logic        start;
  logic [9:0]  imem_count;
  logic [10:0] dmem_count;
  logic [31:0] run_cycles;
  logic [10:0] dump_count;
  logic        cpu_rst_n, cpu_enable, busy, done;

  mem_loader_if bus();

  mem_loader #(.IMEM_DEPTH(512), .DMEM_DEPTH(1024)) dut (
    .clk(clk), .arst(arst), .start(start),
    .imem_count(imem_count), .dmem_count(dmem_count),
    .run_cycles(run_cycles), .dump_count(dump_count),
    .cpu_rst_n(cpu_rst_n), .cpu_enable(cpu_enable),
    .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  // Memories answering the external ports
  logic [31:0] imem [0:511];
  logic [63:0] dmem [0:1023];
  assign bus.rdata_ext = 32'h0;
  always @(posedge clk) begin
    if (bus.wen_ext)   imem[bus.addr_ext[10:2]]   <= bus.wdata_ext;
    if (bus.wen_ext_2) dmem[bus.addr_ext_2[12:3]] <= bus.wdata_ext_2;
    if (bus.ren_ext_2) bus.rdata_ext_2 <= dmem[bus.addr_ext_2[12:3]];
  end

  int total = 0;
  int passed = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h required %h", name, got, exp);
  endtask

  // Expected-behaviour model: what the job must produce, from its parameters alone
  logic [63:0] q_iaddr[$], q_idata[$], q_daddr[$], q_ddata[$], q_out[$];
  logic [63:0] ref_dmem [0:1023];
  logic [63:0] dump_log[$];
  logic [63:0] last_iaddr, last_daddr, held;
  int  iw_seen, dw_seen, en_cnt, en_rises, cyc, rstn_rise_cyc, en_first_cyc;
  bit  armed = 0, loading_open = 0, hold_pending = 0;
  bit  prev_en = 0, prev_rstn = 0, prev_busy = 0, bad;

  function automatic logic [31:0] img_i(input int salt, input int i);
    return (salt == 0) ? 32'h13 : {16'(salt), 16'(i)};
  endfunction
  function automatic logic [63:0] img_d(input int salt, input int i);
    return {32'(salt), 32'((i + 1) * 17)};
  endfunction

  // Per-cycle comparison of DUT activity against the model
  always @(negedge clk) begin
    if (armed) begin
      cyc++;
      bad = (!bus.wen_ext && (bus.addr_ext != 0 || bus.wdata_ext != 0)) || bus.ren_ext ||
            (!bus.wen_ext_2 && !bus.ren_ext_2 && bus.addr_ext_2 != 0) ||
            (!bus.wen_ext_2 && bus.wdata_ext_2 != 0);
      check("ext_idle_zero", 64'(bad), 64'd0);
      check("wen_only_on_accept", 64'((bus.wen_ext || bus.wen_ext_2) && !(bus.in_valid && bus.in_ready)), 64'd0);
      if (bus.in_ready) check("in_ready_only_while_loading", 64'(loading_open), 64'd1);
      if (bus.wen_ext) begin
        iw_seen++; last_iaddr = bus.addr_ext;
        if (q_iaddr.size() == 0) check("imem_extra_write", 64'd1, 64'd0);
        else begin
          check("imem_addr", bus.addr_ext, q_iaddr.pop_front());
          check("imem_data", 64'(bus.wdata_ext), q_idata.pop_front());
        end
      end
      if (bus.wen_ext_2) begin
        dw_seen++; last_daddr = bus.addr_ext_2;
        if (q_daddr.size() == 0) check("dmem_extra_write", 64'd1, 64'd0);
        else begin
          check("dmem_addr", bus.addr_ext_2, q_daddr.pop_front());
          check("dmem_data", bus.wdata_ext_2, q_ddata.pop_front());
        end
      end
      if (bus.out_valid) begin
        if (hold_pending) check("out_data_stable", bus.out_data, held);
        if (bus.out_ready) begin
          hold_pending = 0;
          dump_log.push_back(bus.out_data);
          if (q_out.size() == 0) check("dump_extra_word", 64'd1, 64'd0);
          else check("dump_data", bus.out_data, q_out.pop_front());
        end else begin
          hold_pending = 1; held = bus.out_data;
        end
      end
      if (cpu_rst_n && !prev_rstn) rstn_rise_cyc = cyc;
      if (cpu_enable) begin
        check("enable_needs_rstn", 64'(cpu_rst_n), 64'd1);
        en_cnt++;
        if (!prev_en) begin
          en_rises++; en_first_cyc = cyc;
          check("enable_follows_release", 64'({prev_rstn, prev_en, prev_busy}), 64'b101);
        end
      end
      prev_en = cpu_enable; prev_rstn = cpu_rst_n; prev_busy = busy;
    end
  end

  task automatic run_seq(input int ni, input int nd, input int nr, input int nu,
                         input int salt, input bit toggle, input int hold);
    int ei, ed, eu, sent, tot, t, wcnt;
    bit acc;
    ei = (ni > 512) ? 512 : ni;
    ed = (nd > 1024) ? 1024 : nd;
    eu = (nu > 1024) ? 1024 : nu;
    q_iaddr.delete(); q_idata.delete(); q_daddr.delete(); q_ddata.delete(); q_out.delete();
    dump_log.delete();
    for (int i = 0; i < ei; i++) begin
      q_iaddr.push_back(64'(i * 4)); q_idata.push_back(64'(img_i(salt, i)));
    end
    for (int i = 0; i < ed; i++) begin
      q_daddr.push_back(64'(i * 8)); q_ddata.push_back(img_d(salt, i));
      ref_dmem[i] = img_d(salt, i);
    end
    for (int i = 0; i < eu; i++) q_out.push_back(ref_dmem[i]);
    iw_seen = 0; dw_seen = 0; en_cnt = 0; en_rises = 0;
    rstn_rise_cyc = -100; en_first_cyc = -1; hold_pending = 0;
    tot = ei + ed;
    start = 1'b1;
    imem_count = 10'(ni); dmem_count = 11'(nd); run_cycles = 32'(nr); dump_count = 11'(nu);
    loading_open = (tot > 0);
    @(posedge clk); #1;
    start = 1'b0;
    sent = 0; t = 0;
    while (sent < tot && t < 3000) begin
      bus.in_valid = toggle ? ((t % 2) == 0) : 1'b1;
      bus.in_data  = (sent < ei) ? {32'hFFFF_FFFF, img_i(salt, sent)} : img_d(salt, sent - ei);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      t++;
      if (acc) sent++;
      if (sent >= tot) loading_open = 0;
    end
    bus.in_valid = 1'b0;
    loading_open = 0;
    check("load_complete", 64'(sent), 64'(tot));
    if (tot > 0) check("in_ready_after_load", 64'(bus.in_ready), 64'd0);
    wcnt = 0; t = 0;
    while (!done && t < 5000) begin
      if (bus.out_valid) begin
        if (wcnt >= hold) begin bus.out_ready = 1'b1; wcnt = 0; end
        else begin bus.out_ready = 1'b0; wcnt++; end
      end else bus.out_ready = 1'b0;
      @(posedge clk); #1;
      t++;
    end
    bus.out_ready = 1'b0;
    check("reached_done", 64'(done), 64'd1);
    check("idle_not_busy", 64'(busy), 64'd0);
    check("imem_writes_all_seen", 64'(q_iaddr.size()), 64'd0);
    check("dmem_writes_all_seen", 64'(q_daddr.size()), 64'd0);
    check("dump_all_seen", 64'(q_out.size()), 64'd0);
    check("enable_cycles", 64'(en_cnt), 64'(nr));
    check("enable_one_window", 64'(en_rises), 64'(nr > 0 ? 1 : 0));
  endtask

  initial begin
    int t;
    arst = 1'b1; start = 1'b0;
    imem_count = '0; dmem_count = '0; run_cycles = '0; dump_count = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
    check("rst_cpu_enable", 64'(cpu_enable), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", bus.out_data, 64'd0);
    check("rst_ext", bus.addr_ext | bus.addr_ext_2 | 64'(bus.wen_ext) | 64'(bus.wen_ext_2) | 64'(bus.ren_ext_2), 64'd0);
    arst = 1'b0;
    armed = 1;

    // Two instruction words, nothing else
    run_seq(2, 0, 0, 0, 0, 0, 0);
    check("t1_imem_writes", 64'(iw_seen), 64'd2);
    check("t1_last_iaddr", last_iaddr, 64'd4);
    check("t1_imem1", 64'(imem[1]), 64'h13);

    // Three data words with gappy in_valid
    run_seq(0, 3, 0, 0, 2, 1, 0);
    check("t2_dmem_writes", 64'(dw_seen), 64'd3);
    check("t2_last_daddr", last_daddr, 64'd16);

    // Enable window of five cycles right after RELEASE
    run_seq(1, 1, 5, 0, 3, 0, 0);
    check("t3_en_cnt", 64'(en_cnt), 64'd5);
    check("t3_en_after_release", 64'(en_first_cyc - rstn_rise_cyc), 64'd1);

    // Dump two words with a slow consumer
    run_seq(0, 2, 0, 2, 0, 0, 4);
    check("t4_dump_count", 64'(dump_log.size()), 64'd2);
    if (dump_log.size() == 2) begin
      check("t4_dump0", dump_log[0], 64'h11);
      check("t4_dump1", dump_log[1], 64'h22);
    end

    // Reset in the middle of a ten-cycle run
    en_cnt = 0;
    start = 1'b1; imem_count = '0; dmem_count = '0; run_cycles = 32'd10; dump_count = '0;
    @(posedge clk); #1;
    start = 1'b0;
    t = 0;
    while (en_cnt < 3 && t < 50) begin @(posedge clk); #1; t++; end
    check("t5_reached_run", 64'(en_cnt), 64'd3);
    arst = 1'b1;
    #1;
    check("t5_enable_drops_now", 64'(cpu_enable), 64'd0);
    @(posedge clk); #1;
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
    check("t5_cpu_enable", 64'(cpu_enable), 64'd0);
    check("t5_done", 64'(done), 64'd0);
    arst = 1'b0;
    @(posedge clk); #1;

    // Clean full sequence after reset, then a dump-only job over untouched memory
    run_seq(2, 3, 4, 3, 6, 0, 1);
    run_seq(0, 0, 0, 3, 7, 0, 0);
    if (dump_log.size() == 3) check("t7_dump2", dump_log[2], 64'h0000_0006_0000_0033);

    // Instruction count above depth is clamped
    run_seq(1000, 0, 0, 0, 8, 0, 0);
    check("t8_imem_writes", 64'(iw_seen), 64'd512);
    check("t8_last_iaddr", last_iaddr, 64'd2044);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_loader.md
# mem_loader

Host-side loader/dumper that drives the CPU's external memory ports (`addr_ext*`, `wen_ext*`, `ren_ext*`, `wdata_ext*`, `rdata_ext*`).
- Sequence: accept a program image and a data image over a valid/ready input stream, write them into instruction and data memory, run the CPU for a programmed number of cycles, then stream a window of data memory back out over a valid/ready output stream.
- Sits between the testbench/host link and the `cpu` top; the CPU memories are the responder, this block is the initiator.

## Interface
Parameters:
- IMEM_DEPTH, 512, instruction memory depth in 32-bit words
- DMEM_DEPTH, 1024, data memory depth in 64-bit words

Ports:
- clk  in  1  main clock; everything on rising edge
- arst  in  1  reset, synchronous, active-high
- start  in  1  single-cycle pulse; sampled only in IDLE or DONE
- imem_count  in  10  words to load into instruction memory (latched on start)
- dmem_count  in  11  words to load into data memory (latched on start)
- run_cycles  in  32  cycles to hold cpu_enable high (latched on start)
- dump_count  in  11  data memory words to read back from address 0 (latched on start)
- in_valid / in_ready  in / out  1 / 1  load stream handshake
- in_data  in  64  load word; bits [31:0] used for instruction memory
- out_valid / out_ready  out / in  1 / 1  dump stream handshake
- out_data  out  64  dumped data word
- cpu_rst_n  out  1  to CPU `arst_n`
- cpu_enable  out  1  to CPU `enable`
- addr_ext, wen_ext, ren_ext, wdata_ext  out  64, 1, 1, 32  instruction memory port
- rdata_ext  in  32  instruction memory read data (unused; tied for completeness)
- addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2  out  64, 1, 1, 64  data memory port
- rdata_ext_2  in  64  data memory read data, valid one cycle after ren_ext_2
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  high in DONE

## Operation
Counts above the corresponding depth are clamped to the depth when latched.

States:
- IDLE: cpu_rst_n=0, cpu_enable=0. On start, latch inputs, clear index. Go to the first phase with a nonzero count in the order LOAD_I, LOAD_D, RELEASE.
- LOAD_I: in_ready=1. On in_valid&in_ready, in the same cycle combinationally drive wen_ext=1, addr_ext=idx*4, wdata_ext=in_data[31:0]; then idx++. The accept with idx==imem_count-1 clears idx and goes to LOAD_D, or to RELEASE if dmem_count==0.
- LOAD_D: same scheme with wen_ext_2, addr_ext_2=idx*8, wdata_ext_2=in_data. Last accept goes to RELEASE.
- RELEASE: one cycle, cpu_rst_n=1, cpu_enable=0. Loads cycle counter. Next state is RUN, or DUMP_REQ if run_cycles==0 (DONE if dump_count is also 0).
- RUN: cpu_rst_n=1, cpu_enable=1 for exactly run_cycles cycles. Then DUMP_REQ, or DONE if dump_count==0.
- DUMP_REQ: ren_ext_2=1, addr_ext_2=idx*8; next DUMP_CAP.
- DUMP_CAP: register rdata_ext_2 into out_data; next DUMP_OUT.
- DUMP_OUT: out_valid=1, out_data held stable until out_ready. On handshake, idx++; next DUMP_REQ, or DONE after word dump_count-1.
- DONE: done=1, cpu_rst_n=1, cpu_enable=0. A start pulse restarts as from IDLE.

Rules:
- All wen/ren/addr/wdata outputs are 0 whenever not driven by the current state.
- in_ready is 0 outside the LOAD states.
- start while busy is ignored.

## Timing
- Reset values: state IDLE, all ext outputs 0, cpu_rst_n=0, cpu_enable=0, in_ready=0, out_valid=0, out_data=0, busy=0, done=0.
- Reset asserted mid-operation: next cycle is IDLE with reset values. cpu_enable and out_valid drop immediately. Memory contents are untouched.
- Load throughput: 1 word/cycle when in_valid is held.
- Dump throughput: 1 word per 3 cycles minimum.
- Enable window: cpu_enable rises the cycle after RELEASE and is high for exactly run_cycles consecutive cycles.
- Counters: 32-bit run counter and 11-bit index; no wrap within clamped ranges.

## Test plan
- Reset, then start with imem_count=2, dmem_count=0, run_cycles=0, dump_count=0, stream 0x00000013 twice -> wen_ext pulses at addr_ext 0 and 4; RELEASE follows, then DONE; cpu_enable never high.
- Load dmem_count=3 with in_valid toggled every other cycle -> wen_ext_2 only on accepted cycles, at addresses 0, 8, 16; in_ready=0 after the third accept.
- run_cycles=5 -> cpu_rst_n rises entering RELEASE; cpu_enable is high for exactly 5 cycles starting one cycle after RELEASE.
- Preload data memory with 0x11, 0x22; dump_count=2; out_ready held low for 4 cycles -> out_data=0x11 stays stable while out_valid=1, then 0x22; DONE after second handshake.
- Assert arst during RUN at cycle 3 of 10 -> next cycle IDLE, cpu_enable=0, cpu_rst_n=0, busy=0; later start performs a clean full sequence.
- imem_count=1000 -> clamped to 512; last write at addr_ext 2044.
